// File: rtl/verifier_mul_arbiter_if.sv
// Bus bundle between the requesters, the multiplier arbiter and the shared
// field multiplier. The arbiter connects through the slave modport; the
// requesters and the multiplier together drive the master modport.

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

interface verifier_mul_arbiter_if #(
  parameter int nReq = 4
);

  logic [nReq-1:0]               req_en;
  logic [nReq-1:0][`F_NBITS-1:0] req_in_a;
  logic [nReq-1:0][`F_NBITS-1:0] req_in_b;
  logic [nReq-1:0][`F_NBITS-1:0] req_out;
  logic [nReq-1:0]               req_ready;

  logic                          mul_en;
  logic [1:0][`F_NBITS-1:0]      mul_in;
  logic [`F_NBITS-1:0]           mul_out;
  logic                          mul_ready;

  modport master (
    output req_en, req_in_a, req_in_b, mul_out, mul_ready,
    input  req_out, req_ready, mul_en, mul_in
  );

  modport slave (
    input  req_en, req_in_a, req_in_b, mul_out, mul_ready,
    output req_out, req_ready, mul_en, mul_in
  );

endinterface

// File: rtl/verifier_mul_arbiter.sv
// Round-robin arbiter sharing one field multiplier among nReq requesters.
// Each requester owns an operand slot; a start pulse on an idle slot latches
// the operands and queues the slot. One multiplication is in flight at a time
// and the product is written back bit-exact into the winner's result register.

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module verifier_mul_arbiter #(
  parameter int nReq = 4
) (
  input  logic                 clk,
  input  logic                 rstb,
  verifier_mul_arbiter_if.slave bus
);

  localparam int FW = `F_NBITS;
  localparam int GW = $clog2(nReq);
  // last_grant starts at the top slot so the first grant after reset is slot 0
  localparam logic [GW-1:0] LAST_INIT = GW'(nReq - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [nReq-1:0]         pending;
  logic [nReq-1:0]         accept;
  logic [nReq-1:0]         done_mask;
  logic [nReq-1:0][FW-1:0] slot_a;
  logic [nReq-1:0][FW-1:0] slot_b;
  logic [nReq-1:0][FW-1:0] result;

  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           rr_pick;
  logic [GW-1:0]           rr_cand;
  logic                    rr_found;
  int                      rr_idx;

  logic [1:0][FW-1:0]      mul_in_q;
  logic                    issue_start;
  logic                    complete;

  // A start pulse only counts when the slot is idle; busy slots ignore it.
  assign accept = bus.req_en & ~pending;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int k = 0; k < nReq; k++) begin
      rr_idx  = (int'(last_grant) + 1 + k) % nReq;
      rr_cand = GW'(rr_idx);
      if (!rr_found && pending[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state plus the single-cycle issue/complete strobes.
  always_comb begin
    state_nxt   = state;
    issue_start = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found && bus.mul_ready) begin
          issue_start = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!bus.mul_ready) begin
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.mul_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-hot of the slot finishing this cycle, used to retire it.
  always_comb begin
    done_mask = '0;
    if (complete) begin
      done_mask[grant] = 1'b1;
    end
  end

  // Queue flags: set on accept, cleared when the slot's product lands.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~done_mask) | accept;
    end
  end

  // Operand slots capture the requester's inputs only when accepted.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      slot_a <= '0;
      slot_b <= '0;
    end else begin
      for (int i = 0; i < nReq; i++) begin
        if (accept[i]) begin
          slot_a[i] <= bus.req_in_a[i];
          slot_b[i] <= bus.req_in_b[i];
        end
      end
    end
  end

  // Winner and its operands are frozen at the issue decision and held until
  // the multiplier reports done, so mul_in never sees req_in_* directly.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      grant    <= '0;
      mul_in_q <= '0;
    end else if (issue_start) begin
      grant       <= rr_pick;
      mul_in_q[0] <= slot_a[rr_pick];
      mul_in_q[1] <= slot_b[rr_pick];
    end
  end

  // Round-robin pointer advances only when a grant actually completes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_grant <= LAST_INIT;
    end else if (complete) begin
      last_grant <= grant;
    end
  end

  // Per-slot result registers hold until that slot's next completion.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      result <= '0;
    end else if (complete) begin
      result[grant] <= bus.mul_out;
    end
  end

  assign bus.req_out   = result;
  assign bus.req_ready = ~pending;
  assign bus.mul_en    = (state == ISSUE);
  assign bus.mul_in    = mul_in_q;

endmodule

// File: doc/verifier_mul_arbiter.md
VERIFIER_MUL_ARBITER -- requirements
Module: verifier_mul_arbiter

Interface
REQ-001 Parameter nReq, default 4: number of requesters sharing one field multiplier (2..8).
REQ-002 Parameter field width is `F_NBITS and modulus is `F_Q, both from the common field defines; no local override.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 req_en  input  nReq  per-requester start pulse; operands sampled on the same edge.
REQ-006 req_in_a, req_in_b  input  nReq x `F_NBITS  per-requester operands.
REQ-007 req_out  output  nReq x `F_NBITS  per-requester registered product; holds until that requester's next completion.
REQ-008 req_ready  output  nReq  per-requester level: 1 = idle/result valid, 0 = request queued or in flight.
REQ-009 mul_en  output  1  one-cycle start pulse to the shared multiplier.
REQ-010 mul_in  output  2 x `F_NBITS  operands to the shared multiplier, stable from mul_en until completion.
REQ-011 mul_out  input  `F_NBITS  multiplier product, valid when mul_ready rises.
REQ-012 mul_ready  input  1  multiplier level ready: 1 idle/done, 0 busy.

Function
REQ-013 req_en[i] sampled while req_ready[i]=1: latch operands into slot i; set pending[i]; req_ready[i]=0 from the next cycle.
REQ-014 req_en[i] sampled while req_ready[i]=0: ignored; slot i operands, pending, and output unchanged.
REQ-015 FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI; encoded in a 2-bit register.
REQ-016 IDLE: if any pending and mul_ready=1, select grant g by round-robin from (last_grant+1) mod nReq; go to ISSUE; else stay.
REQ-017 ISSUE: mul_en=1 for exactly this cycle; mul_in = slot g operands; go to WAIT_LO.
REQ-018 WAIT_LO: stay until mul_ready=0, then WAIT_HI; mul_in held.
REQ-019 WAIT_HI: on mul_ready=1, capture mul_out into req_out[g], clear pending[g], set last_grant=g, go to IDLE; req_ready[g]=1 from the next cycle.
REQ-020 Latency with idle arbiter and idle multiplier: req_en at edge k -> mul_en high cycle k+1..k+2 (IDLE decides at edge k+1, ISSUE cycle follows); req_ready rises one cycle after the edge where WAIT_HI sees mul_ready=1.
REQ-021 Request arriving same edge as a completion for another slot: queued; considered in the following IDLE cycle; no request is lost.
REQ-022 Simultaneous req_en on several slots: all queued same edge; served in round-robin order, each exactly once.
REQ-023 Fairness: a pending slot is granted within nReq grants.
REQ-024 mul_en never asserted outside ISSUE; at most one multiplication in flight.
REQ-025 Arbiter performs no arithmetic; req_out[g] is mul_out bit-exact.
REQ-026 mul_in outputs are driven from registered slot operands only (no combinational path from req_in_* to mul_in).

Reset
REQ-027 rstb=0 asynchronously: state=IDLE, pending=0, last_grant=nReq-1 (first grant is slot 0), mul_en=0, mul_in=0, req_out=0, req_ready all 1.
REQ-028 Reset mid-operation discards all queued and in-flight requests; any later mul_ready edge from an in-flight multiply is ignored; IDLE issues nothing until mul_ready=1.

Verification (bench uses a behavioural multiplier: ready falls the cycle after mul_en, rises 3 cycles later with (a*b) mod `F_Q)
REQ-029 Single request: req_en[0], a=3, b=5 -> one mul_en pulse, req_out[0]=15, req_ready[0] low then high, other slots untouched.
REQ-030 All four req_en same edge, a_i=i+2, b_i=7 -> grants 0,1,2,3 in order, req_out={14,21,28,35}, exactly four mul_en pulses.
REQ-031 Round-robin: after slot 2 served, slots 0 and 3 pending -> slot 3 granted before slot 0.
REQ-032 req_en[1] repeated while req_ready[1]=0 with different operands -> ignored; req_out[1] reflects first operands only.
REQ-033 rstb pulsed low during WAIT_HI -> all outputs at reset values immediately; late mul_ready rise writes no req_out.
REQ-034 Random mix of 1000 requests with random field operands (full `F_NBITS width) -> every accepted request completes once, products match reference (a*b) mod `F_Q, no mul_en while mul_ready=0.
